// File: rtl/ccd_timing_generator_if.sv
// rtl/ccd_timing_generator_if.sv - control and waveform signal bundle for the CCD timing generator
//
// Purpose: groups the run controls and every generated waveform/status signal.
// Ports (seen from the timing generator, modport slave):
//   i_enable, i_start          in   run permit, frame start request
//   contador[31:0]             out  cycle position within the current line
//   o_phi_l2, o_phi_p          out  vertical transfer and summing clocks
//   o_phi_h1, o_phi_h2         out  horizontal register clocks
//   o_reset_gate               out  output-node reset gate
//   o_row_index[15:0]          out  current line index
//   o_busy, o_row_done,
//   o_frame_done               out  readout active, line-end pulse, frame-end pulse
// The master modport is the controlling side (sequencer or bench).
interface ccd_timing_generator_if;
    logic        i_enable;
    logic        i_start;
    logic [31:0] contador;
    logic        o_phi_l2;
    logic        o_phi_p;
    logic        o_phi_h1;
    logic        o_phi_h2;
    logic        o_reset_gate;
    logic [15:0] o_row_index;
    logic        o_busy;
    logic        o_row_done;
    logic        o_frame_done;

    modport master (
        output i_enable, i_start,
        input  contador, o_phi_l2, o_phi_p, o_phi_h1, o_phi_h2, o_reset_gate,
        input  o_row_index, o_busy, o_row_done, o_frame_done
    );

    modport slave (
        input  i_enable, i_start,
        output contador, o_phi_l2, o_phi_p, o_phi_h1, o_phi_h2, o_reset_gate,
        output o_row_index, o_busy, o_row_done, o_frame_done
    );
endinterface

// File: rtl/ccd_timing_generator.sv
// rtl/ccd_timing_generator.sv - CCD line/frame readout clock generator
//
// Purpose: on a start request, sweeps contador through each line of L = 2053*C
// cycles for ROWS lines, producing vertical, summing, horizontal and reset-gate
// clocks from the position within the line.
// Ports:
//   i_clock     in   system clock, rising edge
//   i_reset_n   in   asynchronous active-low reset
//   bus         slave modport of ccd_timing_generator_if (controls and outputs)
module ccd_timing_generator #(
    parameter int CICLOS_FORMAS_DE_ONDA = 8,
    parameter int ROWS                  = 512
) (
    input  logic                     i_clock,
    input  logic                     i_reset_n,
    ccd_timing_generator_if.slave    bus
);
    localparam logic [31:0] C        = 32'(CICLOS_FORMAS_DE_ONDA);
    localparam logic [31:0] LAST_CNT = 32'(2053 * CICLOS_FORMAS_DE_ONDA - 1);
    localparam logic [15:0] LAST_ROW = 16'(ROWS - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t      state, state_n;
    logic [31:0] cnt_n;
    logic [15:0] row_n;
    // Phase within the current waveform unit, i.e. contador mod C. The pixel
    // window starts at 5C, a multiple of C, so this equals the pixel phase
    // there without needing a divider.
    logic [31:0] phase, phase_n;
    logic        run_n, pix_n;
    logic        phi_l2_n, phi_p_n, phi_h1_n, phi_h2_n, rg_n;
    logic        row_done_n, frame_done_n;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) state <= IDLE;
        else            state <= state_n;
    end

    // Every output is derived from the next-cycle position so the registered
    // waveforms line up with the contador value shown in the same cycle.
    always_comb begin
        state_n = state;
        cnt_n   = '0;
        row_n   = '0;
        phase_n = '0;
        case (state)
            IDLE: begin
                if (bus.i_enable && bus.i_start) state_n = RUN;
            end
            RUN: begin
                if (!bus.i_enable) begin
                    state_n = IDLE;
                end else if (bus.contador == LAST_CNT) begin
                    if (bus.o_row_index == LAST_ROW) state_n = IDLE;
                    else                             row_n   = bus.o_row_index + 16'd1;
                end else begin
                    cnt_n   = bus.contador + 32'd1;
                    row_n   = bus.o_row_index;
                    phase_n = (phase == C - 32'd1) ? 32'd0 : phase + 32'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        run_n        = (state_n == RUN);
        pix_n        = run_n && (cnt_n >= 5 * C);
        phi_l2_n     = run_n && (cnt_n >= C)     && (cnt_n < 3 * C);
        phi_p_n      = run_n && (cnt_n >= 2 * C) && (cnt_n < 4 * C);
        phi_h1_n     = pix_n ? (phase_n < C / 2) : 1'b1;
        phi_h2_n     = pix_n && (phase_n >= C / 2);
        rg_n         = pix_n && (phase_n < C / 4);
        row_done_n   = run_n && (cnt_n == LAST_CNT);
        frame_done_n = row_done_n && (row_n == LAST_ROW);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            phase            <= '0;
            bus.contador     <= '0;
            bus.o_row_index  <= '0;
            bus.o_busy       <= 1'b0;
            bus.o_row_done   <= 1'b0;
            bus.o_frame_done <= 1'b0;
            bus.o_phi_l2     <= 1'b0;
            bus.o_phi_p      <= 1'b0;
            bus.o_phi_h1     <= 1'b1;
            bus.o_phi_h2     <= 1'b0;
            bus.o_reset_gate <= 1'b0;
        end else begin
            phase            <= phase_n;
            bus.contador     <= cnt_n;
            bus.o_row_index  <= row_n;
            bus.o_busy       <= run_n;
            bus.o_row_done   <= row_done_n;
            bus.o_frame_done <= frame_done_n;
            bus.o_phi_l2     <= phi_l2_n;
            bus.o_phi_p      <= phi_p_n;
            bus.o_phi_h1     <= phi_h1_n;
            bus.o_phi_h2     <= phi_h2_n;
            bus.o_reset_gate <= rg_n;
        end
    end
endmodule

// File: tb/tb_ccd_timing_generator.sv
// tb/tb_ccd_timing_generator.sv - scoreboard bench for ccd_timing_generator
module tb_ccd_timing_generator;
    localparam int C    = 8;
    localparam int ROWS = 2;
    localparam int L    = 2053 * C;

    logic clk;
    logic rst_n;

    ccd_timing_generator_if bus_if ();

    ccd_timing_generator #(
        .CICLOS_FORMAS_DE_ONDA(C),
        .ROWS                 (ROWS)
    ) dut (
        .i_clock  (clk),
        .i_reset_n(rst_n),
        .bus      (bus_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned cnt;
        int unsigned row;
        bit busy, l2, p, h1, h2, rg, rd, fd;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: readout position as plain integers.
    bit          m_run = 0;
    int unsigned m_cnt = 0;
    int unsigned m_row = 0;

    task automatic chk(input string name, input longint act, input longint req);
        total++;
        if (act != req) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        bit   pix;
        int unsigned p;
        e.cnt  = m_cnt;
        e.row  = m_row;
        e.busy = m_run;
        e.l2   = m_run && m_cnt >= C && m_cnt < 3 * C;
        e.p    = m_run && m_cnt >= 2 * C && m_cnt < 4 * C;
        pix    = m_run && m_cnt >= 5 * C && m_cnt < 2053 * C;
        p      = pix ? (m_cnt - 5 * C) % C : 0;
        e.h1   = pix ? (p < C / 2) : 1'b1;
        e.h2   = pix && (p >= C / 2);
        e.rg   = pix && (p < C / 4);
        e.rd   = m_run && m_cnt == L - 1;
        e.fd   = e.rd && m_row == ROWS - 1;
        return e;
    endfunction

    // Apply inputs for one clock edge, advance the model and queue the outcome.
    task automatic step(input bit en, input bit st);
        bus_if.i_enable = en;
        bus_if.i_start  = st;
        @(posedge clk);
        if (!m_run) begin
            if (en && st) begin
                m_run = 1; m_cnt = 0; m_row = 0;
            end
        end else if (!en) begin
            m_run = 0; m_cnt = 0; m_row = 0;
        end else if (m_cnt == L - 1) begin
            m_cnt = 0;
            if (m_row == ROWS - 1) begin
                m_run = 0; m_row = 0;
            end else begin
                m_row++;
            end
        end else begin
            m_cnt++;
        end
        exp_q.push_back(model_outputs());
        #1;
    endtask

    task automatic check_reset_levels(input string tag);
        chk({tag, "_cnt"},  bus_if.contador,     0);
        chk({tag, "_row"},  bus_if.o_row_index,  0);
        chk({tag, "_busy"}, bus_if.o_busy,       0);
        chk({tag, "_rd"},   bus_if.o_row_done,   0);
        chk({tag, "_fd"},   bus_if.o_frame_done, 0);
        chk({tag, "_l2"},   bus_if.o_phi_l2,     0);
        chk({tag, "_p"},    bus_if.o_phi_p,      0);
        chk({tag, "_h1"},   bus_if.o_phi_h1,     1);
        chk({tag, "_h2"},   bus_if.o_phi_h2,     0);
        chk({tag, "_rg"},   bus_if.o_reset_gate, 0);
    endtask

    // Monitor: one expected entry per clock, compared half a period later.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            chk("cnt",  bus_if.contador,     e.cnt);
            chk("row",  bus_if.o_row_index,  e.row);
            chk("busy", bus_if.o_busy,       e.busy);
            chk("l2",   bus_if.o_phi_l2,     e.l2);
            chk("p",    bus_if.o_phi_p,      e.p);
            chk("h1",   bus_if.o_phi_h1,     e.h1);
            chk("h2",   bus_if.o_phi_h2,     e.h2);
            chk("rg",   bus_if.o_reset_gate, e.rg);
            chk("rd",   bus_if.o_row_done,   e.rd);
            chk("fd",   bus_if.o_frame_done, e.fd);
        end
    end

    initial begin
        rst_n           = 1'b0;
        bus_if.i_enable = 1'b0;
        bus_if.i_start  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_levels("rst_init");
        #2 rst_n = 1'b1;

        // Idle behaviour: no start, and start while disabled.
        repeat (5) step(1, 0);
        repeat (5) step(0, 1);

        // Full frame with spurious start requests sprinkled through it.
        step(1, 1);
        for (int i = 0; i < 2 * L + 10; i++) step(1, ($urandom_range(0, 15) == 0));

        // Abort by dropping enable partway through a line.
        step(1, 1);
        repeat (1000) step(1, 0);
        repeat (4) step(0, 0);
        repeat (3) step(1, 0);

        // Asynchronous reset in the middle of a line.
        step(1, 1);
        repeat ($urandom_range(100, 3000)) step(1, $urandom_range(0, 1));
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1 check_reset_levels("rst_async");
        @(posedge clk);
        #1 check_reset_levels("rst_held");
        @(negedge clk);
        #2 rst_n = 1'b1;
        m_run = 0; m_cnt = 0; m_row = 0;
        repeat (5) step(1, 0);

        // Random control activity.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 63) != 0), ($urandom_range(0, 7) == 0));

        @(negedge clk);
        #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
